calc_input_sequencer: RTL

Operand/opcode entry stage that sits directly upstream of the calculator datapath on the FPGA board. It debounces three push-buttons and steps a four-state entry FSM that commits the 4-bit switch bank into registered `A`, `B` and `operation` outputs. It flags a complete operand set with `result_valid` so the downstream BCD/display path shows only committed results.

---
 rtl/calc_input_sequencer.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/calc_input_sequencer.sv
// calc_input_sequencer
// -----------------------------------------------------------------------------
// Operand/opcode entry stage in front of the calculator datapath.
//
// Each push-button is debounced and turned into a single-cycle press pulse.
// A four-state entry FSM uses the pulses to commit the switch bank into the
// registered operands A and B and the 3-bit opcode. result_valid marks a
// complete operand set (SHOW state).
//
// Build option:
//   CALC_SEQ_SYNC_EN - when defined, every raw input (sw bus and the three
//                      buttons) passes through a 2-flop synchronizer reset to
//                      0. Button latency grows by 2 cycles and sw is seen 2
//                      cycles late. When undefined, the raw inputs are used
//                      directly (simulation, or an external synchronizer).
//
// Reset: rst is asynchronous and active-low for every flop in this file.
// -----------------------------------------------------------------------------

// Debouncer: a level change is accepted only after DEBOUNCE_CYCLES
// consecutive cycles of disagreement with the stable level. The press pulse
// is registered together with the stable level, so it is high exactly in the
// cycle following the 0->1 acceptance edge.
module calc_seq_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic press_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [CW-1:0] ZERO  = CW'(0);

    logic          stable_q;
    logic          stable_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_inc_s;
    logic          press_q;
    logic          press_d;

    // Next-state logic: count disagreement, accept the new level at the limit.
    always_comb begin
        stable_d  = stable_q;
        cnt_d     = ZERO;
        press_d   = 1'b0;
        cnt_inc_s = cnt_q + ONE;
        if (btn_in != stable_q) begin
            if (cnt_inc_s == LIMIT) begin
                // Level accepted; only a rising acceptance produces a press.
                stable_d = btn_in;
                cnt_d    = ZERO;
                press_d  = btn_in;
            end else begin
                cnt_d    = cnt_inc_s;
            end
        end else begin
            // Any agreement restarts the count, so short glitches are ignored.
            cnt_d = ZERO;
        end
    end

    // Debouncer state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable_q <= 1'b0;
            cnt_q    <= ZERO;
            press_q  <= 1'b0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// Top level: input conditioning, three debouncers and the entry FSM.
module calc_input_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       btn_enter,
    input  logic       btn_back,
    input  logic       btn_clear,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [2:0] operation,
    output logic [1:0] stage,
    output logic       result_valid
);

    typedef enum logic [1:0] {
        ST_ENTER_A  = 2'b00,
        ST_ENTER_B  = 2'b01,
        ST_ENTER_OP = 2'b10,
        ST_SHOW     = 2'b11
    } state_e;

    // Conditioned copies of the raw inputs.
    logic [3:0] sw_s;
    logic       enter_raw_s;
    logic       back_raw_s;
    logic       clear_raw_s;

`ifdef CALC_SEQ_SYNC_EN
    // Bit layout: {sw[3:0], btn_clear, btn_back, btn_enter}.
    logic [6:0] sync1_q;
    logic [6:0] sync2_q;

    // Two-flop synchronizer for all asynchronous board inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 7'b000_0000;
            sync2_q <= 7'b000_0000;
        end else begin
            sync1_q <= {sw, btn_clear, btn_back, btn_enter};
            sync2_q <= sync1_q;
        end
    end

    assign sw_s        = sync2_q[6:3];
    assign clear_raw_s = sync2_q[2];
    assign back_raw_s  = sync2_q[1];
    assign enter_raw_s = sync2_q[0];
`else
    assign sw_s        = sw;
    assign clear_raw_s = btn_clear;
    assign back_raw_s  = btn_back;
    assign enter_raw_s = btn_enter;
`endif

    // One-cycle press pulses.
    logic enter_p_s;
    logic back_p_s;
    logic clear_p_s;

    calc_seq_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_enter (
        .clk    (clk),
        .rst    (rst),
        .btn_in (enter_raw_s),
        .press_o(enter_p_s)
    );

    calc_seq_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_back (
        .clk    (clk),
        .rst    (rst),
        .btn_in (back_raw_s),
        .press_o(back_p_s)
    );

    calc_seq_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_clear (
        .clk    (clk),
        .rst    (rst),
        .btn_in (clear_raw_s),
        .press_o(clear_p_s)
    );

    // FSM and committed operand registers.
    state_e     state_q;
    state_e     state_d;
    logic [3:0] a_q;
    logic [3:0] a_d;
    logic [3:0] b_q;
    logic [3:0] b_d;
    logic [2:0] op_q;
    logic [2:0] op_d;
    logic       valid_q;
    logic       valid_d;

    // Entry FSM next state: clear beats back beats enter; lower ones dropped.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        if (clear_p_s) begin
            state_d = ST_ENTER_A;
            a_d     = 4'h0;
            b_d     = 4'h0;
            op_d    = 3'b000;
        end else if (back_p_s) begin
            // Step back one stage; committed values are left untouched.
            case (state_q)
                ST_ENTER_A:  state_d = ST_ENTER_A;
                ST_ENTER_B:  state_d = ST_ENTER_A;
                ST_ENTER_OP: state_d = ST_ENTER_B;
                ST_SHOW:     state_d = ST_ENTER_OP;
                default:     state_d = ST_ENTER_A;
            endcase
        end else if (enter_p_s) begin
            // Commit the switches for the current stage and advance.
            case (state_q)
                ST_ENTER_A: begin
                    a_d     = sw_s;
                    state_d = ST_ENTER_B;
                end
                ST_ENTER_B: begin
                    b_d     = sw_s;
                    state_d = ST_ENTER_OP;
                end
                ST_ENTER_OP: begin
                    op_d    = sw_s[2:0];
                    state_d = ST_SHOW;
                end
                ST_SHOW: begin
                    // Start a new entry round; keep the shown values.
                    state_d = ST_ENTER_A;
                end
                default: begin
                    state_d = ST_ENTER_A;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        // result_valid is registered alongside the state it describes.
        valid_d = (state_d == ST_SHOW);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_ENTER_A;
            a_q     <= 4'h0;
            b_q     <= 4'h0;
            op_q    <= 3'b000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            valid_q <= valid_d;
        end
    end

    assign A            = a_q;
    assign B            = b_q;
    assign operation    = op_q;
    assign stage        = state_q;
    assign result_valid = valid_q;

endmodule
